instr_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the 16-bit PC register.
- Takes the current PC, runs a req/ack handshake with instruction memory, and holds the fetched word plus its PC in an instruction register for decode.
- Pulses pc_advance so the PC register's next-PC logic steps forward only once an instruction has been fetched.
- Supports decode stall and branch/jump flush.

---
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one memory request per PC, holds the returned word for decode,
// and pulses pc_advance once per fetched instruction. Handles stall, flush and ack watchdog.
module instr_fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    input  logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              pc_advance,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_ERR
    } state_t;

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TMO = (CNT_W + 1)'(ACK_TIMEOUT);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CNT_W:0]     cnt_inc;
    logic               wd_hit;
    logic               req_nx, valid_nx, adv_nx, err_nx;
    logic [ADDR_W-1:0]  addr_nx, irpc_nx;
    logic [DATA_W-1:0]  out_nx;

    // cnt holds the number of completed ack-less request cycles
    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign wd_hit  = (ACK_TIMEOUT != 0) && !mem_ack && (cnt_inc == TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir_out     <= '0;
            ir_pc      <= '0;
            ir_valid   <= 1'b0;
            pc_advance <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            mem_req    <= req_nx;
            mem_addr   <= addr_nx;
            ir_out     <= out_nx;
            ir_pc      <= irpc_nx;
            ir_valid   <= valid_nx;
            pc_advance <= adv_nx;
            fetch_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = mem_req;
        addr_nx  = mem_addr;
        out_nx   = ir_out;
        irpc_nx  = ir_pc;
        valid_nx = ir_valid;
        adv_nx   = 1'b0;
        err_nx   = fetch_err;
        unique case (state)
            S_IDLE: state_nx = S_NEXT;
            S_NEXT: begin
                valid_nx = 1'b0;
                if (!flush) begin
                    addr_nx  = pc_in;
                    req_nx   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    req_nx = 1'b0;
                    if (flush) begin
                        state_nx = S_NEXT;
                    end else begin
                        out_nx   = mem_rdata;
                        irpc_nx  = mem_addr;
                        valid_nx = 1'b1;
                        adv_nx   = 1'b1;
                        state_nx = S_HOLD;
                    end
                end else if (wd_hit) begin
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    cnt_nx = cnt_inc[CNT_W-1:0];
                    if (flush) state_nx = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush || !stall) begin
                    valid_nx = 1'b0;
                    state_nx = S_NEXT;
                end
            end
            S_DRAIN: begin
                // the request cannot be withdrawn; wait it out and drop the data
                if (mem_ack) begin
                    req_nx   = 1'b0;
                    state_nx = S_NEXT;
                end else if (wd_hit) begin
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    cnt_nx = cnt_inc[CNT_W-1:0];
                end
            end
            S_ERR: begin
                req_nx   = 1'b0;
                valid_nx = 1'b0;
                err_nx   = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed walk through the fetch scenarios, then a
// randomized run checked against transaction-level rules of the fetch protocol.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in, mem_rdata, redirect;
    logic        flush, stall, mem_ack;
    logic        mem_req, ir_valid, pc_advance, fetch_err;
    logic [15:0] mem_addr, ir_out, ir_pc;

    logic [15:0] b_pc = 16'h0100;
    logic        b_zero = 1'b0;
    logic [15:0] b_rdata = 16'h0000;
    logic        b_req, b_valid, b_adv, b_err;
    logic [15:0] b_addr, b_out, b_irpc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .ACK_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir_out(ir_out), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .pc_advance(pc_advance), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .ACK_TIMEOUT(0)) u_nowd (
        .clk(clk), .rst(rst), .pc_in(b_pc), .flush(b_zero), .stall(b_zero),
        .mem_req(b_req), .mem_addr(b_addr), .mem_ack(b_zero),
        .mem_rdata(b_rdata), .ir_out(b_out), .ir_pc(b_irpc),
        .ir_valid(b_valid), .pc_advance(b_adv), .fetch_err(b_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_req"}, mem_req, 1'b0);
        chk16({tag, "_addr"}, mem_addr, 16'h0000);
        chk16({tag, "_ir"}, ir_out, 16'h0000);
        chk16({tag, "_irpc"}, ir_pc, 16'h0000);
        chk1({tag, "_valid"}, ir_valid, 1'b0);
        chk1({tag, "_adv"}, pc_advance, 1'b0);
        chk1({tag, "_err"}, fetch_err, 1'b0);
    endtask

    // Program image seen by the fetch unit
    function automatic logic [15:0] word(input logic [15:0] a);
        return (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
    endfunction

    // One clock; the bench plays the PC register (redirect wins over advance)
    task automatic cyc();
        logic adv, fl;
        adv = pc_advance;
        fl  = flush;
        @(posedge clk);
        #1;
        if (fl) pc_in = redirect;
        else if (adv) pc_in = pc_in + 16'h0001;
    endtask

    logic        p_req, p_valid, p_stall, p_flush;
    logic [15:0] p_addr, p_out, p_irpc;
    int          req_run, delivered;

    initial begin
        rst = 1'b0; pc_in = 16'h0000; flush = 1'b0; stall = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0000; redirect = 16'h0000;
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_held");
        rst = 1'b0;

        cyc();
        chk1("c1_req", mem_req, 1'b0);
        cyc();
        chk1("c2_req", mem_req, 1'b1);
        chk16("c2_addr", mem_addr, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        cyc();
        mem_ack = 1'b0; mem_rdata = 16'hDEAD;
        chk16("f0_ir", ir_out, 16'h1234);
        chk16("f0_irpc", ir_pc, 16'h0000);
        chk1("f0_valid", ir_valid, 1'b1);
        chk1("f0_adv", pc_advance, 1'b1);
        chk1("f0_req", mem_req, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk1("stall_valid", ir_valid, 1'b1);
            chk16("stall_ir", ir_out, 16'h1234);
            chk1("stall_req", mem_req, 1'b0);
            chk1("stall_adv", pc_advance, 1'b0);
        end
        stall = 1'b0;
        cyc();
        chk1("acc_valid", ir_valid, 1'b0);
        chk1("acc_req", mem_req, 1'b0);
        cyc();
        chk1("f1_req", mem_req, 1'b1);
        chk16("f1_addr", mem_addr, 16'h0001);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        cyc();
        mem_ack = 1'b0;
        chk1("f1_adv", pc_advance, 1'b1);
        chk16("f1_irpc", ir_pc, 16'h0001);
        cyc();
        chk1("f1_acc", ir_valid, 1'b0);
        cyc();
        chk1("f2_req", mem_req, 1'b1);
        chk16("f2_addr", mem_addr, 16'h0002);

        flush = 1'b1; redirect = 16'h0040;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk1("drain_req", mem_req, 1'b1);
            chk16("drain_addr", mem_addr, 16'h0002);
            cyc();
        end
        chk1("drain_req3", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        cyc();
        mem_ack = 1'b0;
        chk1("drop_req", mem_req, 1'b0);
        chk1("drop_valid", ir_valid, 1'b0);
        chk1("drop_adv", pc_advance, 1'b0);
        chk1("drop_err", fetch_err, 1'b0);
        cyc();
        chk1("redir_req", mem_req, 1'b1);
        chk16("redir_addr", mem_addr, 16'h0040);

        flush = 1'b1; redirect = 16'h0080;
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        cyc();
        flush = 1'b0; mem_ack = 1'b0;
        chk1("fa_valid", ir_valid, 1'b0);
        chk1("fa_adv", pc_advance, 1'b0);
        chk1("fa_req", mem_req, 1'b0);
        cyc();
        chk1("fa_rereq", mem_req, 1'b1);
        chk16("fa_addr", mem_addr, 16'h0080);
        mem_ack = 1'b1; mem_rdata = 16'h4321;
        cyc();
        mem_ack = 1'b0;
        chk16("f3_ir", ir_out, 16'h4321);
        chk1("f3_valid", ir_valid, 1'b1);
        stall = 1'b1; flush = 1'b1; redirect = 16'h00C0;
        cyc();
        flush = 1'b0; stall = 1'b0;
        chk1("fh_valid", ir_valid, 1'b0);
        chk1("fh_adv", pc_advance, 1'b0);
        cyc();
        chk1("to_req", mem_req, 1'b1);
        chk16("to_addr", mem_addr, 16'h00C0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk1("to_req_n", mem_req, 1'b1);
            chk1("to_err_n", fetch_err, 1'b0);
        end
        cyc();
        chk1("to_err", fetch_err, 1'b1);
        chk1("to_req_off", mem_req, 1'b0);
        chk1("to_valid", ir_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            flush = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            cyc();
            chk1("stuck_err", fetch_err, 1'b1);
            chk1("stuck_req", mem_req, 1'b0);
            chk1("stuck_valid", ir_valid, 1'b0);
            chk1("stuck_adv", pc_advance, 1'b0);
        end
        mem_ack = 1'b0; flush = 1'b0; stall = 1'b0;
        chk1("nowd_err", b_err, 1'b0);
        chk1("nowd_req", b_req, 1'b1);
        chk16("nowd_addr", b_addr, 16'h0100);

        #2 rst = 1'b1;
        #1 chk_zero("rst_err");
        @(posedge clk);
        #1 pc_in = 16'h0200; rst = 1'b0;
        cyc();
        cyc();
        chk1("rr_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1 chk1("mid_req", mem_req, 1'b0);
        chk1("mid_valid", ir_valid, 1'b0);
        chk1("mid_err", fetch_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        cyc();
        chk1("rs_req", mem_req, 1'b1);
        chk16("rs_addr", mem_addr, 16'h0200);

        #2 rst = 1'b1;
        @(posedge clk);
        #1 pc_in = 16'hFFFD; rst = 1'b0;
        req_run = 0;
        delivered = 0;
        for (int n = 0; n < 800; n++) begin
            if (mem_req) req_run++;
            else req_run = 0;
            if (mem_req) mem_ack = (req_run >= 4) || ($urandom_range(0, 99) < 45);
            else mem_ack = ($urandom_range(0, 99) < 15);
            mem_rdata = (mem_ack && mem_req) ? word(mem_addr) : 16'($urandom);
            stall = ($urandom_range(0, 99) < 35);
            flush = ($urandom_range(0, 99) < 7);
            redirect = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            p_req = mem_req; p_addr = mem_addr; p_valid = ir_valid;
            p_out = ir_out; p_irpc = ir_pc; p_stall = stall; p_flush = flush;
            cyc();
            chk1("rnd_err", fetch_err, 1'b0);
            if (p_flush) begin
                chk1("rnd_fl_valid", ir_valid, 1'b0);
                chk1("rnd_fl_adv", pc_advance, 1'b0);
            end else if (p_valid) begin
                if (p_stall) begin
                    chk1("rnd_hold_valid", ir_valid, 1'b1);
                    chk16("rnd_hold_ir", ir_out, p_out);
                    chk16("rnd_hold_pc", ir_pc, p_irpc);
                    chk1("rnd_hold_adv", pc_advance, 1'b0);
                end else begin
                    chk1("rnd_acc", ir_valid, 1'b0);
                end
            end
            if (pc_advance) begin
                delivered++;
                chk1("rnd_adv_valid", ir_valid, 1'b1);
                chk1("rnd_adv_new", p_valid, 1'b0);
                chk16("rnd_irpc", ir_pc, pc_in);
                chk16("rnd_ir", ir_out, word(ir_pc));
            end
            if (p_req && mem_req) chk16("rnd_addr_hold", mem_addr, p_addr);
            if (!p_req && mem_req) chk16("rnd_req_addr", mem_addr, pc_in);
        end
        flush = 1'b0; stall = 1'b0; mem_ack = 1'b0;
        chk1("rnd_progress", delivered > 40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
